// File: rtl/bexkat2_intctrl_pkg.sv
// Shared constants, FSM state type and helpers for the bexkat2 interrupt controller.
package bexkat1Def;

  localparam int NUM_IRQ      = 8;
  // Exception vector index of line 0; the CPU adds vec_o to it.
  localparam int IRQ_VEC_BASE = 8;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_REQ,
    IC_SERVICE
  } intctrl_state_t;

  function automatic logic [NUM_IRQ-1:0] irq_onehot(input logic [2:0] idx);
    return {{(NUM_IRQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/bexkat2_intctrl_prienc.sv
// Combinational 8-to-3 priority encoder; bit 0 has the highest priority.
module bexkat2_prienc
  import bexkat1Def::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic [2:0]         idx,
  output logic               valid
);

  // Scanning from the lowest priority upward leaves the lowest set index in idx.
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/bexkat2_intctrl.sv
// Fixed-priority interrupt controller for the bexkat2 CPU.
// Define BEXKAT2_INT_NESTING_EN to let higher-priority lines preempt one in service.
module bexkat2_intctrl
  import bexkat1Def::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  mask_i,
  input  logic                int_en_i,
  output logic                exc_req_o,
  input  logic                exc_ack_i,
  output logic [2:0]          vec_o,
  input  logic                eoi_i,
  output logic [NUM_IRQ-1:0]  pending_o,
  output logic [NUM_IRQ-1:0]  active_o
);

  logic [NUM_IRQ-1:0] sync1, sync2, sync_prev, edge_q;
  logic [1:0]         fill_cnt;
  intctrl_state_t     state;

  logic [2:0]         win_idx, act_idx;
  logic               win_valid, act_valid;
  logic [NUM_IRQ-1:0] candidates, ack_clear, active_rest;

  // Edges are only reported once sync_prev holds a real post-reset sample,
  // so a line held high across reset release is never seen as rising.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      edge_q    <= '0;
      fill_cnt  <= '0;
    end else begin
      sync1     <= irq_i;
      sync2     <= sync1;
      sync_prev <= sync2;
      edge_q    <= (fill_cnt == 2'd3) ? (sync2 & ~sync_prev) : '0;
      if (fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
    end
  end

`ifdef BEXKAT2_INT_NESTING_EN
  logic [NUM_IRQ-1:0] above_active;

  always_comb begin
    above_active = '1;
    if (act_valid) above_active = irq_onehot(act_idx) - 1'b1;
  end

  assign candidates = pending_o & mask_i & above_active;
`else
  assign candidates = pending_o & mask_i;
`endif

  bexkat2_prienc u_win_enc (
    .req   (candidates),
    .idx   (win_idx),
    .valid (win_valid)
  );

  bexkat2_prienc u_act_enc (
    .req   (active_o),
    .idx   (act_idx),
    .valid (act_valid)
  );

  assign ack_clear   = (state == IC_REQ && exc_ack_i) ? irq_onehot(vec_o) : '0;
  assign active_rest = active_o & ~irq_onehot(act_idx);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IC_IDLE;
      exc_req_o <= 1'b0;
      vec_o     <= '0;
      pending_o <= '0;
      active_o  <= '0;
    end else begin
      // A new edge coinciding with the ack clear keeps the line pending.
      pending_o <= (pending_o & ~ack_clear) | edge_q;
      unique case (state)
        IC_IDLE: begin
          if (int_en_i && win_valid) begin
            state     <= IC_REQ;
            vec_o     <= win_idx;
            exc_req_o <= 1'b1;
          end
        end
        IC_REQ: begin
          if (exc_ack_i) begin
            active_o  <= active_o | irq_onehot(vec_o);
            state     <= IC_SERVICE;
            exc_req_o <= 1'b0;
          end else if (!int_en_i) begin
            exc_req_o <= 1'b0;
            state     <= (|active_o) ? IC_SERVICE : IC_IDLE;
          end
        end
        IC_SERVICE: begin
          if (eoi_i && act_valid) begin
            active_o <= active_rest;
            state    <= (|active_rest) ? IC_SERVICE : IC_IDLE;
          end
`ifdef BEXKAT2_INT_NESTING_EN
          else if (int_en_i && win_valid) begin
            state     <= IC_REQ;
            vec_o     <= win_idx;
            exc_req_o <= 1'b1;
          end
`endif
        end
        default: state <= IC_IDLE;
      endcase
    end
  end

endmodule
